// File: rtl/sha256_pad_ctrl_pkg.sv
// Shared widths, padding constants and FSM state encoding for the SHA-256
// message padding sequencer.
package sha256_pad_ctrl_pkg;

  localparam int unsigned BLK_W       = 512;
  localparam int unsigned LEN_FIELD_W = 64;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLK_BYTES   = BLK_W / BYTE_W;

  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h80;
  localparam int unsigned LEN_FIELD_OFS  = 56;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad80,
    StLength,
    StIssue,
    StWait
  } state_e;

endpackage

// File: rtl/sha256_blk_buf.sv
// 64-byte block register, big-endian byte order (byte 0 in the top byte lane),
// with a byte write port, a 64-bit length write port and a synchronous clear.
module sha256_blk_buf
  import sha256_pad_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   byte_we_i,
  input  logic [5:0]             byte_idx_i,
  input  logic [BYTE_W-1:0]      byte_data_i,
  input  logic                   len_we_i,
  input  logic [LEN_FIELD_W-1:0] len_data_i,
  output logic [BLK_W-1:0]       block_o
);

  localparam int unsigned LenTop = BLK_W - 1 - BYTE_W * LEN_FIELD_OFS;

  logic [BLK_W-1:0] blk_d, blk_q;

  always_comb begin
    blk_d = blk_q;
    if (clr_i) begin
      blk_d = '0;
    end else begin
      for (int i = 0; i < BLK_BYTES; i++) begin
        if (byte_we_i && (byte_idx_i == 6'(i))) begin
          blk_d[BLK_W-1-BYTE_W*i -: BYTE_W] = byte_data_i;
        end
      end
      if (len_we_i) begin
        blk_d[LenTop -: LEN_FIELD_W] = len_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_q <= '0;
    end else begin
      blk_q <= blk_d;
    end
  end

  assign block_o = blk_q;

endmodule

// File: rtl/sha256_pad_ctrl.sv
// Packs a byte stream into 512-bit SHA-256 blocks, appends the 0x80 / zero /
// bit-length padding and hands each block to the compression core.
module sha256_pad_ctrl
  import sha256_pad_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  input  logic             IN_EMPTY,
  output logic             IN_READY,
  output logic [BLK_W-1:0] CORE_BLOCK,
  output logic             CORE_INIT,
  output logic             CORE_NEXT,
  input  logic             CORE_READY,
  input  logic             CORE_DONE,
  output logic             BUSY,
  output logic             DONE,
  output logic             LEN_ERR
);

  state_e           state_d, state_q;
  logic [5:0]       idx_d, idx_q;
  logic [LEN_W-1:0] cnt_d, cnt_q;
  logic             first_d, first_q;
  logic             pad_pend_d, pad_pend_q;
  logic             len_pend_d, len_pend_q;
  logic             final_d, final_q;
  logic             done_d, done_q;
  logic             len_err_d, len_err_q;

  logic                   byte_we, len_we, blk_clr;
  logic [BYTE_W-1:0]      byte_data;
  logic [LEN_FIELD_W-1:0] len_data;
  logic                   accept, has_byte;

  assign IN_READY = (state_q == StIdle) || (state_q == StFill);
  assign accept   = IN_VALID && IN_READY;
  assign has_byte = !(IN_LAST && IN_EMPTY);
  assign len_data = LEN_FIELD_W'({cnt_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    pad_pend_d = pad_pend_q;
    len_pend_d = len_pend_q;
    final_d    = final_q;
    done_d     = 1'b0;
    len_err_d  = len_err_q;
    byte_we    = 1'b0;
    byte_data  = IN_DATA;
    len_we     = 1'b0;
    blk_clr    = 1'b0;
    CORE_INIT  = 1'b0;
    CORE_NEXT  = 1'b0;

    unique case (state_q)
      StIdle, StFill: begin
        if (accept) begin
          if (state_q == StIdle) begin
            len_err_d = 1'b0;
            state_d   = StFill;
          end
          if (has_byte) begin
            byte_we = 1'b1;
            idx_d   = idx_q + 6'd1;
            // Saturate rather than wrap; the length field is then wrong, so flag it.
            if (&cnt_q) begin
              len_err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
            if (idx_q == 6'd63) begin
              state_d    = StIssue;
              pad_pend_d = IN_LAST;
            end else if (IN_LAST) begin
              state_d = StPad80;
            end
          end else begin
            state_d = StPad80;
          end
        end
      end

      StPad80: begin
        byte_we   = 1'b1;
        byte_data = PAD_BYTE;
        if (idx_q <= 6'(LEN_FIELD_OFS - 1)) begin
          state_d = StLength;
        end else begin
          state_d    = StIssue;
          len_pend_d = 1'b1;
        end
      end

      StLength: begin
        len_we  = 1'b1;
        final_d = 1'b1;
        state_d = StIssue;
      end

      StIssue: begin
        if (CORE_READY) begin
          CORE_INIT = first_q;
          CORE_NEXT = !first_q;
          first_d   = 1'b0;
          state_d   = StWait;
        end
      end

      StWait: begin
        if (CORE_DONE) begin
          blk_clr = 1'b1;
          idx_d   = '0;
          if (final_q) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            first_d = 1'b1;
            final_d = 1'b0;
            state_d = StIdle;
          end else if (pad_pend_q) begin
            pad_pend_d = 1'b0;
            state_d    = StPad80;
          end else if (len_pend_q) begin
            len_pend_d = 1'b0;
            state_d    = StLength;
          end else begin
            state_d = StFill;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      pad_pend_q <= 1'b0;
      len_pend_q <= 1'b0;
      final_q    <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      pad_pend_q <= pad_pend_d;
      len_pend_q <= len_pend_d;
      final_q    <= final_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
    end
  end

  sha256_blk_buf u_blk_buf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clr_i       (blk_clr),
    .byte_we_i   (byte_we),
    .byte_idx_i  (idx_q),
    .byte_data_i (byte_data),
    .len_we_i    (len_we),
    .len_data_i  (len_data),
    .block_o     (CORE_BLOCK)
  );

  assign BUSY    = (state_q != StIdle);
  assign DONE    = done_q;
  assign LEN_ERR = len_err_q;

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Randomised bench for sha256_pad_ctrl: messages are padded by a byte-level
// reference model and compared block by block against what the core receives.
module tb_sha256_pad_ctrl;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [7:0]   IN_DATA = 8'h00;
  logic         IN_VALID = 1'b0, IN_LAST = 1'b0, IN_EMPTY = 1'b0;
  logic         IN_READY;
  logic [511:0] CORE_BLOCK;
  logic         CORE_INIT, CORE_NEXT;
  logic         CORE_READY = 1'b1;
  logic         CORE_DONE = 1'b0;
  logic         BUSY, DONE, LEN_ERR;

  // Narrow-counter instance sharing all inputs; only its LEN_ERR is examined.
  logic         s_in_ready, s_init, s_next, s_busy, s_done, s_len_err;
  logic [511:0] s_block;

  sha256_pad_ctrl #(.LEN_W(32)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .IN_EMPTY(IN_EMPTY), .IN_READY(IN_READY), .CORE_BLOCK(CORE_BLOCK),
    .CORE_INIT(CORE_INIT), .CORE_NEXT(CORE_NEXT), .CORE_READY(CORE_READY),
    .CORE_DONE(CORE_DONE), .BUSY(BUSY), .DONE(DONE), .LEN_ERR(LEN_ERR)
  );

  sha256_pad_ctrl #(.LEN_W(4)) dut_small (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .IN_EMPTY(IN_EMPTY), .IN_READY(s_in_ready), .CORE_BLOCK(s_block),
    .CORE_INIT(s_init), .CORE_NEXT(s_next), .CORE_READY(CORE_READY),
    .CORE_DONE(CORE_DONE), .BUSY(s_busy), .DONE(s_done), .LEN_ERR(s_len_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   msg[$];
  logic [511:0] exp_q[$];
  logic [511:0] obs_q[$];
  bit           obs_init[$];

  int           pend = 0, both_cnt = 0, unstable_cnt = 0;
  int           cd_cyc = 0, init_cyc = 0, acc_cyc = 0, done_cyc = 0, ready_viol = 0;
  bit           timeout = 1'b0;
  logic [511:0] held_blk = '0;

  // Core model: capture each issued block, answer with CORE_DONE after 1..4 cycles.
  always @(negedge CLK) begin
    if (CORE_DONE) CORE_DONE = 1'b0;
    if (CORE_INIT === 1'b1 && CORE_NEXT === 1'b1) both_cnt++;
    if (pend > 0) begin
      if (CORE_BLOCK !== held_blk) unstable_cnt++;
      pend--;
      if (pend == 0) begin
        CORE_DONE = 1'b1;
        cd_cyc    = cyc;
      end
    end
    if (CORE_INIT === 1'b1 || CORE_NEXT === 1'b1) begin
      obs_q.push_back(CORE_BLOCK);
      obs_init.push_back(CORE_INIT);
      held_blk = CORE_BLOCK;
      pend     = int'($urandom_range(1, 4));
      if (CORE_INIT === 1'b1) init_cyc = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "simulation time limit");
  end

  task automatic fill_rand(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic fill_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic build_expected();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] blk;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_q.push_back(blk);
    end
  endtask

  task automatic put_beat(input logic [7:0] d, input bit last, input bit empty);
    int guard = 0;
    IN_DATA  = d;
    IN_LAST  = last;
    IN_EMPTY = empty;
    IN_VALID = 1'b1;
    while (IN_READY !== 1'b1 && guard < 3000) begin
      @(negedge CLK);
      guard++;
    end
    if (IN_READY !== 1'b1) timeout = 1'b1;
    acc_cyc = cyc;
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    IN_EMPTY = 1'b0;
  endtask

  task automatic send_msg(input bit empty_tail);
    obs_q.delete();
    obs_init.delete();
    timeout = 1'b0;
    for (int i = 0; i < msg.size(); i++) begin
      repeat ($urandom_range(0, 1)) @(negedge CLK);
      if (i == msg.size() - 1) put_beat(msg[i], !empty_tail, 1'b0);
      else put_beat(msg[i], 1'b0, 1'($urandom_range(0, 1)));
    end
    if (empty_tail || msg.size() == 0) put_beat(8'($urandom_range(0, 255)), 1'b1, 1'b1);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    ready_viol = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        done_cyc = cyc;
        got      = 1'b1;
        break;
      end
      if (IN_READY !== 1'b0) ready_viol++;
    end
    if (!got) timeout = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if (IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    else n_pass++;
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY);
    else n_pass++;
    n_checks++;
    if ({CORE_INIT, CORE_NEXT, DONE, LEN_ERR} !== 4'b0000)
      $display("FAIL reset_pulses: got %b want 0000", {CORE_INIT, CORE_NEXT, DONE, LEN_ERR});
    else n_pass++;
    n_checks++;
    if (CORE_BLOCK !== 512'h0) $display("FAIL reset_block: got %h want 0", CORE_BLOCK);
    else n_pass++;
  endtask

  task automatic test_abc();
    logic [511:0] lit;
    lit = {32'h61626380, 416'h0, 64'h18};
    fill_abc();
    build_expected();
    send_msg(1'b0);
    wait_done();
    n_checks++;
    if (timeout || obs_q.size() != 1)
      $display("FAIL abc_blocks: got %0d blocks timeout=%b want 1 block", obs_q.size(), timeout);
    else n_pass++;
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0] !== lit || exp_q[0] !== lit)
        $display("FAIL abc_block: got %h want %h", obs_q[0], lit);
      else n_pass++;
      n_checks++;
      if (obs_init[0] !== 1'b1) $display("FAIL abc_init: got next want init");
      else n_pass++;
    end
    n_checks++;
    if (init_cyc - acc_cyc != 3)
      $display("FAIL abc_latency: got %0d want 3", init_cyc - acc_cyc);
    else n_pass++;
    n_checks++;
    if (done_cyc - cd_cyc != 1)
      $display("FAIL abc_done_latency: got %0d want 1", done_cyc - cd_cyc);
    else n_pass++;
  endtask

  task automatic test_lengths();
    int lens[$];
    int n;
    bit et;
    lens = '{0, 1, 55, 56, 63, 64, 65, 119, 120, 128};
    repeat (6) lens.push_back(int'($urandom_range(0, 200)));
    foreach (lens[li]) begin
      n  = lens[li];
      et = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      fill_rand(n);
      build_expected();
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send_msg(et);
      wait_done();
      n_checks++;
      if (timeout || obs_q.size() != exp_q.size())
        $display("FAIL len%0d_count: got %0d blocks timeout=%b want %0d", n, obs_q.size(),
                 timeout, exp_q.size());
      else n_pass++;
      for (int b = 0; b < obs_q.size() && b < exp_q.size(); b++) begin
        n_checks++;
        if (obs_q[b] !== exp_q[b] || obs_init[b] !== (b == 0))
          $display("FAIL len%0d_blk%0d: got %h init=%b want %h init=%b", n, b, obs_q[b],
                   obs_init[b], exp_q[b], (b == 0));
        else n_pass++;
      end
      n_checks++;
      if (ready_viol != 0 || done_cyc - cd_cyc != 1)
        $display("FAIL len%0d_tail: got ready_viol=%0d done_lat=%0d want 0 and 1", n,
                 ready_viol, done_cyc - cd_cyc);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [511:0] snap;
    int bad = 0;
    fill_abc();
    build_expected();
    CORE_READY = 1'b0;
    send_msg(1'b0);
    repeat (2) @(negedge CLK);
    snap = CORE_BLOCK;
    repeat (10) begin
      @(negedge CLK);
      if (CORE_INIT !== 1'b0 || CORE_NEXT !== 1'b0 || CORE_BLOCK !== snap || BUSY !== 1'b1)
        bad++;
    end
    n_checks++;
    if (bad != 0 || obs_q.size() != 0)
      $display("FAIL stall_hold: got %0d bad cycles %0d pulses want 0 0", bad, obs_q.size());
    else n_pass++;
    n_checks++;
    if (snap !== exp_q[0]) $display("FAIL stall_block: got %h want %h", snap, exp_q[0]);
    else n_pass++;
    CORE_READY = 1'b1;
    wait_done();
    n_checks++;
    if (timeout || obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      $display("FAIL stall_release: got %0d blocks timeout=%b want 1 matching", obs_q.size(),
               timeout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    fill_rand(10);
    obs_q.delete();
    obs_init.delete();
    foreach (msg[i]) put_beat(msg[i], 1'b0, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0 || CORE_BLOCK !== 512'h0)
      $display("FAIL rstmid_state: got ready=%b busy=%b blk_nz=%b want 1 0 0", IN_READY, BUSY,
               (CORE_BLOCK != 512'h0));
    else n_pass++;
    repeat (5) begin
      @(negedge CLK);
      if (DONE !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0 || obs_q.size() != 0)
      $display("FAIL rstmid_pulses: got done=%0d core=%0d want 0 0", pulses, obs_q.size());
    else n_pass++;
    fill_abc();
    build_expected();
    send_msg(1'b0);
    wait_done();
    n_checks++;
    if (timeout || obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_init[0] !== 1'b1)
      $display("FAIL rstmid_abc: got %0d blocks timeout=%b want 1 init block", obs_q.size(),
               timeout);
    else n_pass++;
  endtask

  task automatic test_len_err();
    fill_rand(16);
    send_msg(1'($urandom_range(0, 1)));
    wait_done();
    n_checks++;
    if (s_len_err !== 1'b1) $display("FAIL lenerr_16: got %b want 1", s_len_err);
    else n_pass++;
    n_checks++;
    if (LEN_ERR !== 1'b0) $display("FAIL lenerr_wide: got %b want 0", LEN_ERR);
    else n_pass++;
    fill_rand(15);
    send_msg(1'b0);
    wait_done();
    n_checks++;
    if (s_len_err !== 1'b0) $display("FAIL lenerr_15: got %b want 0", s_len_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_lengths();
    test_stall();
    test_reset_mid();
    test_len_err();
    n_checks++;
    if (both_cnt != 0 || unstable_cnt != 0)
      $display("FAIL core_protocol: got both=%0d unstable=%0d want 0 0", both_cnt, unstable_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_pad_ctrl.md
Name: sha256_pad_ctrl

Overview:
Message sequencer between the UART byte receive path and the SHA-256 compression core inside the hashing control unit. Accepts a byte stream with an end-of-message marker and packs it big-endian into 512-bit blocks. Applies FIPS 180-4 padding (0x80, zero fill, 64-bit bit-length) and issues each block to the core with an init or next pulse. Waits for block completion and signals when the final digest is valid.

Parameters:
LEN_W, 32, width of the message byte counter; the 64-bit length field is (count*8) zero-extended.

Ports:
CLK  in  1  system clock; the single clock for the block.
RST  in  1  reset, synchronous, active-high.
IN_DATA  in  8  message byte.
IN_VALID  in  1  IN_DATA / IN_LAST / IN_EMPTY valid.
IN_LAST  in  1  this beat ends the message.
IN_EMPTY  in  1  with IN_LAST: beat carries no byte (zero-length tail or empty message); ignored when IN_LAST=0.
IN_READY  out  1  controller accepts a beat when IN_VALID & IN_READY.
CORE_BLOCK  out  512  current block; byte 0 at [511:504].
CORE_INIT  out  1  1-cycle pulse: compress first block of a message.
CORE_NEXT  out  1  1-cycle pulse: compress a subsequent block.
CORE_READY  in  1  core idle and able to take a pulse.
CORE_DONE  in  1  1-cycle pulse: core finished the issued block.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  1-cycle pulse: final block compressed; the core digest is valid.
LEN_ERR  out  1  sticky: byte counter overflowed during the current message.

Behaviour:
- Interface as decided: one clock, CLK; reset RST is synchronous and active-high.
- Reset: state IDLE, block register 0, byte index 0, count 0, first-block flag 1. IN_READY=1 (combinational from state). All other outputs 0. Reset mid-operation aborts the message with no pulses emitted.
- States: IDLE, FILL, PAD80, LENGTH, ISSUE, WAIT. IN_READY=1 only in IDLE and FILL.
- Accepted data beat (IN_EMPTY=0 or IN_LAST=0):
  - Write IN_DATA at index idx; idx+1; count+1.
  - If count would wrap past 2^LEN_W-1, set LEN_ERR and saturate count. Hashing continues.
  - IDLE goes to FILL on the first beat and clears LEN_ERR.
- Block full (64th byte accepted):
  - Next state ISSUE; a pad_pending flag records whether IN_LAST was set.
  - After that block's WAIT, pad_pending=1 goes to PAD80 at idx 0; otherwise go to FILL.
- Last beat with byte at idx<63: next PAD80. Last beat with IN_EMPTY=1: no write; next PAD80 at the current idx.
- PAD80 (1 cycle):
  - Write 0x80 at idx.
  - If idx<=55, go to LENGTH.
  - Else go to ISSUE with a length_pending flag set. After that block's WAIT, go to LENGTH.
- LENGTH (1 cycle): bytes 56..63 = {zero-ext, count, 3'b000}; set final flag; go to ISSUE.
- ISSUE: hold until CORE_READY=1. Then pulse CORE_INIT if the first-block flag is 1, else CORE_NEXT. Clear the first-block flag and go to WAIT.
- WAIT:
  - CORE_BLOCK is held stable until CORE_DONE.
  - On CORE_DONE: clear the block register to 0 and set idx=0.
  - If final: pulse DONE the next cycle, reset count and first-block flag, go to IDLE. Otherwise go to FILL / PAD80 / LENGTH per the pending flags.
- Zero fill is implicit: the block register is cleared after every block, so there is no per-byte zero padding.
- Latency, single-block message, CORE_READY=1: last byte accepted at cycle t; PAD80 at t+1; LENGTH at t+2; CORE_INIT at t+3.
- CORE_DONE outside WAIT is ignored. CORE_INIT and CORE_NEXT are never high together. IN_VALID during non-ready states is not consumed.

Decomposition:
- Shared package/define file:
  - state encodings;
  - block/word widths (512, 64, 8);
  - PAD_BYTE=8'h80;
  - LEN_FIELD_OFS=56.
- Optional sub-module sha256_blk_buf: the 64-byte register with byte-write, 64-bit length-write and synchronous clear ports. The FSM stays in the top.

Test Plan:
- "abc" (0x61,0x62,0x63, IN_LAST on 0x63):
  - CORE_BLOCK = 0x61626380, then zeros, last 64 bits = 0x18.
  - One CORE_INIT at t+3; DONE one cycle after CORE_DONE.
  - With the real core, digest = ba7816bf…f20015ad.
- Empty message (IN_LAST=1, IN_EMPTY=1):
  - Block = 0x80, then zeros, length 0; one CORE_INIT.
  - With the real core, digest e3b0c442…7852b855.
- 55-byte message:
  - Single block, 0x80 at byte 55, length 0x1B8.
- 56-byte message:
  - Block 1 has 0x80 at byte 56 and is issued with CORE_INIT.
  - Block 2 is all zero except length 0x1C0 and is issued with CORE_NEXT.
- 64-byte message:
  - Block 1 is pure data.
  - Block 2 = 0x80 at byte 0, length 0x200.
  - IN_READY is low from the 64th byte until DONE.
- Stalls and reset:
  - Hold CORE_READY low 10 cycles in ISSUE: no pulse is emitted and CORE_BLOCK is stable.
  - Assert RST mid-FILL: the next cycle shows IDLE, IN_READY=1, no pulses. A following "abc" still hashes correctly.
  - With LEN_W=4, send 16 bytes: LEN_ERR goes to 1.
